mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single DPI-backed memory port (`mem_read`-style: addr/en/rdata, plus write strobes) between the instruction-fetch stage and the load/store unit. Each requester issues a valid/ready request. The arbiter grants one transaction at a time with round-robin priority, holds the memory port for a fixed latency, and returns a one-cycle response pulse to the winner. It sits between `inst_if`/LSU and the memory model in the NPC top level.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- `MEM_LAT`, default 1: cycles the port is held before `mem_rdata` is sampled. Must be at least 1.

- `clock`  in  1  sole clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_addr`  in  ADDR_W  fetch address.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_resp_valid`  out  1  one-cycle fetch data pulse.
- `if_resp_data`  out  DATA_W  fetch read data.
- `ls_req_valid`  in  1  LSU request.
- `ls_req_addr`  in  ADDR_W  LSU address.
- `ls_req_wen`  in  1  1 = write, 0 = read.
- `ls_req_wdata`  in  DATA_W  write data.
- `ls_req_wmask`  in  DATA_W/8  byte enables.
- `ls_req_ready`  out  1  LSU request accepted this cycle.
- `ls_resp_valid`  out  1  one-cycle LSU completion pulse.
- `ls_resp_data`  out  DATA_W  read data; 0 for writes.
- `mem_en`  out  1  memory port enable.
- `mem_wen`  out  1  write strobe.
- `mem_addr`  out  ADDR_W  port address.
- `mem_wdata`  out  DATA_W  port write data.
- `mem_wmask`  out  DATA_W/8  port byte enables.
- `mem_rdata`  in  DATA_W  port read data, valid while `mem_en` is high.

## Operation
- State machine: IDLE → WAIT → RESP → IDLE.
- **IDLE**
  - If any request is valid, select a winner and assert only the winner's `*_req_ready` (combinational).
  - The handshake completes in that cycle. Latch address, wen, wdata, wmask and the winner ID. Go to WAIT. Load the counter with MEM_LAT-1.
- **Arbitration**
  - A sole requester always wins.
  - On a tie, the winner is the requester not granted last. `last_grant` updates on every handshake.
  - `last_grant` resets to LSU, so IF wins the first tie.
- **WAIT**
  - `mem_en`=1. `mem_addr`, `mem_wdata` and `mem_wmask` come from the latched values.
  - `mem_wen`=latched wen during the first WAIT cycle only, then 0. This gives exactly one write per transaction.
  - The counter decrements each cycle. When it is 0: capture `mem_rdata` (0 if the transaction is a write) into the response register and go to RESP.
- **RESP**
  - Assert the winner's `*_resp_valid` for exactly one cycle, with the data held in that cycle. Return to IDLE.
  - No response backpressure: the requester must consume the pulse.
- IF transactions are always reads: latched wen=0, wmask=0.
- Only one transaction is outstanding at a time. `*_req_ready` is 0 in WAIT and RESP.
- Outside WAIT: `mem_en`, `mem_wen`, `mem_addr`, `mem_wdata` and `mem_wmask` are all 0.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator):
  - state=IDLE, counter=0, `last_grant`=LSU.
  - All outputs 0 except the combinational readies, which follow IDLE rules once `reset` is high.
- Handshake in cycle T:
  - WAIT in T+1..T+MEM_LAT; `mem_rdata` is sampled at the end of T+MEM_LAT.
  - `*_resp_valid` is high in T+MEM_LAT+1.
  - The next handshake is possible at T+MEM_LAT+2 at the earliest.
  - Throughput is one transaction per MEM_LAT+2 cycles.
- Requests deasserted or changed during WAIT/RESP are ignored. A request must be held until ready.
- Reset mid-WAIT or mid-RESP: the transaction is dropped and no response is issued. A write already strobed stays committed.
- Simultaneous events:
  - A new request in a RESP cycle waits for IDLE.
  - Both requesters valid in every IDLE cycle → strict alternation IF, LS, IF, LS…

## Test plan
- IF only, addr 0x8000_0000, MEM_LAT=1, `mem_rdata`=0x0000_0000_0013_0413:
  - `if_req_ready` in cycle T; `mem_en`=1 with `mem_addr`=0x8000_0000 in T+1.
  - `if_resp_valid`=1 with data 0x…0413 in T+2; `ls_resp_valid` stays 0.
- LSU write, addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F, MEM_LAT=3:
  - `mem_wen` high for exactly one cycle (T+1); `mem_en` high T+1..T+3.
  - `ls_resp_valid` in T+4 with data 0.
- Both valid continuously from reset for 6 grants:
  - Grant order IF, LS, IF, LS, IF, LS; each response goes only to the matching requester.
- IF valid asserted during an LSU WAIT: `if_req_ready` stays 0 until the IDLE cycle after `ls_resp_valid`, then goes to 1.
- `reset` pulled low in the second WAIT cycle (MEM_LAT=3):
  - All outputs 0 immediately; no resp pulse appears.
  - After release, the first tie goes to IF.
- LSU read with `mem_rdata` changing every cycle, MEM_LAT=2: `ls_resp_data` equals the value present in cycle T+2 only.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and the LSU.
// One transaction at a time: IDLE grant, MEM_LAT cycles holding the port, one-cycle response.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_resp_data,

    input  logic                  ls_req_valid,
    input  logic [ADDR_W-1:0]     ls_req_addr,
    input  logic                  ls_req_wen,
    input  logic [DATA_W-1:0]     ls_req_wdata,
    input  logic [DATA_W/8-1:0]   ls_req_wmask,
    output logic                  ls_req_ready,
    output logic                  ls_resp_valid,
    output logic [DATA_W-1:0]     ls_resp_data,

    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {GRANT_IF = 1'b0, GRANT_LS = 1'b1} grant_t;

    state_t           state;
    grant_t           last_grant;
    grant_t           owner;
    logic [CNT_W-1:0] count;
    logic             txn_wen;
    logic             pick_ls;

    // The LSU wins when it is alone or when fetch held the previous grant.
    // Readies are held low while reset is asserted so every output is quiet.
    always_comb begin
        pick_ls      = ls_req_valid && (!if_req_valid || last_grant == GRANT_IF);
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        if (reset && state == IDLE) begin
            if_req_ready = if_req_valid && !pick_ls;
            ls_req_ready = pick_ls;
        end
    end

    // The mem_* registers double as the latched request; mem_wen is dropped
    // after the first WAIT cycle so a write is strobed exactly once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= GRANT_LS;
            owner         <= GRANT_IF;
            count         <= '0;
            txn_wen       <= 1'b0;
            mem_en        <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ls_req_ready) begin
                        state      <= WAIT;
                        count      <= CNT_LOAD;
                        owner      <= GRANT_LS;
                        last_grant <= GRANT_LS;
                        txn_wen    <= ls_req_wen;
                        mem_en     <= 1'b1;
                        mem_wen    <= ls_req_wen;
                        mem_addr   <= ls_req_addr;
                        mem_wdata  <= ls_req_wdata;
                        mem_wmask  <= ls_req_wmask;
                    end else if (if_req_ready) begin
                        state      <= WAIT;
                        count      <= CNT_LOAD;
                        owner      <= GRANT_IF;
                        last_grant <= GRANT_IF;
                        txn_wen    <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_wen    <= 1'b0;
                        mem_addr   <= if_req_addr;
                        mem_wdata  <= '0;
                        mem_wmask  <= '0;
                    end
                end
                WAIT: begin
                    mem_wen <= 1'b0;
                    if (count == '0) begin
                        state     <= RESP;
                        mem_en    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        if (owner == GRANT_LS) begin
                            ls_resp_valid <= 1'b1;
                            ls_resp_data  <= txn_wen ? '0 : mem_rdata;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= mem_rdata;
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    if_resp_valid <= 1'b0;
                    if_resp_data  <= '0;
                    ls_resp_valid <= 1'b0;
                    ls_resp_data  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-level timing model plus response scoreboard
// drives a MEM_LAT=3 instance; a MEM_LAT=1 instance covers the single-cycle fetch case.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    typedef struct {
        logic [63:0] data;
        int          due;
    } resp_t;

    logic        clock;
    logic        reset;

    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_req_addr, if_resp_data;
    logic        ls_req_valid, ls_req_wen, ls_req_ready, ls_resp_valid;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
    logic [7:0]  ls_req_wmask;
    logic        mem_en, mem_wen;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    logic        b_if_req_valid, b_if_req_ready, b_if_resp_valid;
    logic [63:0] b_if_req_addr, b_if_resp_data;
    logic        b_ls_req_valid, b_ls_req_wen, b_ls_req_ready, b_ls_resp_valid;
    logic [63:0] b_ls_req_addr, b_ls_req_wdata, b_ls_resp_data;
    logic [7:0]  b_ls_req_wmask;
    logic        b_mem_en, b_mem_wen;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [7:0]  b_mem_wmask;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cyc = -100;
    int          hs_count = 0;
    int          last_hs_cyc = -1;
    bit          last_hs_ls = 1'b0;
    bit          last_ls = 1'b1;
    logic        hs_wen = 1'b0;
    logic [63:0] hs_addr = '0;
    logic [63:0] hs_wdata = '0;
    logic [7:0]  hs_wmask = '0;
    resp_t       if_q[$];
    resp_t       ls_q[$];
    bit          grants[$];
    int          grant_cycles[$];

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut_lat1 (
        .clock(clock), .reset(reset),
        .if_req_valid(b_if_req_valid), .if_req_addr(b_if_req_addr), .if_req_ready(b_if_req_ready),
        .if_resp_valid(b_if_resp_valid), .if_resp_data(b_if_resp_data),
        .ls_req_valid(b_ls_req_valid), .ls_req_addr(b_ls_req_addr), .ls_req_wen(b_ls_req_wen),
        .ls_req_wdata(b_ls_req_wdata), .ls_req_wmask(b_ls_req_wmask), .ls_req_ready(b_ls_req_ready),
        .ls_resp_valid(b_ls_resp_valid), .ls_resp_data(b_ls_resp_data),
        .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Read data changes every cycle so a response proves which cycle was sampled.
    function automatic logic [63:0] pat(input int c);
        return {32'hC0DE_0000 + 32'(c), 32'h5A5A_0000 ^ 32'(c)};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
        mem_rdata = pat(cyc);
    endtask

    // Compares every output against the timing model, then records the handshake
    // the model predicts for this cycle (completed at the coming rising edge).
    task automatic check_output();
        logic  idle, win, exp_if_rdy, exp_ls_rdy;
        resp_t r;
        #1;
        if (!reset) begin
            if_q.delete();
            ls_q.delete();
            hs_cyc  = -100;
            last_ls = 1'b1;
        end
        idle       = reset && (cyc > hs_cyc + LAT + 1);
        exp_if_rdy = idle && if_req_valid && (!ls_req_valid || last_ls);
        exp_ls_rdy = idle && ls_req_valid && (!if_req_valid || !last_ls);
        win        = reset && (cyc >= hs_cyc + 1) && (cyc <= hs_cyc + LAT);

        check("if_req_ready", 64'(if_req_ready), 64'(exp_if_rdy));
        check("ls_req_ready", 64'(ls_req_ready), 64'(exp_ls_rdy));
        check("mem_en", 64'(mem_en), 64'(win));
        check("mem_wen", 64'(mem_wen), 64'(win && hs_wen && cyc == hs_cyc + 1));
        check("mem_addr", mem_addr, win ? hs_addr : 64'h0);
        check("mem_wdata", mem_wdata, win ? hs_wdata : 64'h0);
        check("mem_wmask", 64'(mem_wmask), win ? 64'(hs_wmask) : 64'h0);

        if (if_q.size() > 0 && if_q[0].due == cyc) begin
            r = if_q.pop_front();
            check("if_resp_valid", 64'(if_resp_valid), 64'h1);
            check("if_resp_data", if_resp_data, r.data);
        end else begin
            check("if_resp_valid_quiet", 64'(if_resp_valid), 64'h0);
        end
        if (ls_q.size() > 0 && ls_q[0].due == cyc) begin
            r = ls_q.pop_front();
            check("ls_resp_valid", 64'(ls_resp_valid), 64'h1);
            check("ls_resp_data", ls_resp_data, r.data);
        end else begin
            check("ls_resp_valid_quiet", 64'(ls_resp_valid), 64'h0);
        end

        if (exp_if_rdy) begin
            hs_cyc = cyc; hs_wen = 1'b0; hs_addr = if_req_addr; hs_wdata = '0; hs_wmask = '0;
            if_q.push_back('{data: pat(cyc + LAT), due: cyc + LAT + 1});
            last_ls = 1'b0;
        end
        if (exp_ls_rdy) begin
            hs_cyc = cyc; hs_wen = ls_req_wen; hs_addr = ls_req_addr;
            hs_wdata = ls_req_wdata; hs_wmask = ls_req_wmask;
            ls_q.push_back('{data: ls_req_wen ? 64'h0 : pat(cyc + LAT), due: cyc + LAT + 1});
            last_ls = 1'b1;
        end
        if (exp_if_rdy || exp_ls_rdy) begin
            hs_count++;
            last_hs_cyc = cyc;
            last_hs_ls  = exp_ls_rdy;
            grants.push_back(exp_ls_rdy);
            grant_cycles.push_back(cyc);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic ifv, input logic [63:0] ifa,
                                  input logic lsv, input logic [63:0] lsa, input logic wen,
                                  input logic [63:0] wdata, input logic [7:0] wmask);
        next_cycle();
        reset        = rst;
        if_req_valid = ifv;
        if_req_addr  = ifa;
        ls_req_valid = lsv;
        ls_req_addr  = lsa;
        ls_req_wen   = wen;
        ls_req_wdata = wdata;
        ls_req_wmask = wmask;
        check_output();
    endtask

    task automatic step_cycle();
        next_cycle();
        check_output();
    endtask

    task automatic wait_grant(input int start, input bit want_ls, input int budget, output int at);
        int n = 0;
        while (hs_count == start && n < budget) begin
            step_cycle();
            n++;
        end
        check("grant_in_budget", 64'(hs_count != start), 64'h1);
        check("grant_winner", 64'(last_hs_ls), 64'(want_ls));
        at = last_hs_cyc;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((if_q.size() != 0 || ls_q.size() != 0) && n < budget) begin
            step_cycle();
            n++;
        end
        check("drain_done", 64'(if_q.size() + ls_q.size()), 64'h0);
        step_cycle();
        step_cycle();
    endtask

    initial begin
        int s, n, t_ls, t_if;
        reset = 1'b1;
        {if_req_valid, ls_req_valid, ls_req_wen} = '0;
        {if_req_addr, ls_req_addr, ls_req_wdata} = '0;
        ls_req_wmask = '0;
        {b_if_req_valid, b_ls_req_valid, b_ls_req_wen} = '0;
        {b_if_req_addr, b_ls_req_addr, b_ls_req_wdata} = '0;
        b_ls_req_wmask = '0;
        b_mem_rdata = 64'h0000_0000_0013_0413;
        mem_rdata = pat(0);
        #2 reset = 1'b0;

        // Reset with both requesting: everything stays quiet.
        apply_stimulus(1'b0, 1'b1, 64'h8000_0000, 1'b1, 64'h8000_1000, 1'b0, 64'h0, 8'h0);
        step_cycle();

        // Both valid continuously from reset release: IF, LS, IF, LS, IF, LS.
        apply_stimulus(1'b1, 1'b1, 64'h8000_0000, 1'b1, 64'h8000_1000, 1'b0, 64'h0, 8'h0);
        n = 0;
        while (grants.size() < 6 && n < 60) begin
            step_cycle();
            n++;
        end
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
        check("alt_grant_count", 64'(grants.size()), 64'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            check($sformatf("alt_grant_%0d", i), 64'(grants[i]), 64'(i % 2));
        for (int i = 1; i < 6 && i < grant_cycles.size(); i++)
            check($sformatf("alt_spacing_%0d", i), 64'(grant_cycles[i] - grant_cycles[i-1]), 64'(LAT + 2));
        drain(20);

        // LSU write, then IF requests during the LSU WAIT and must wait for IDLE.
        s = hs_count;
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0100, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        wait_grant(s, 1'b1, 10, t_ls);
        s = hs_count;
        apply_stimulus(1'b1, 1'b1, 64'h8000_0200, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
        wait_grant(s, 1'b0, 20, t_if);
        check("if_waits_for_idle", 64'(t_if - t_ls), 64'(LAT + 2));
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
        drain(20);

        // Reset in the second WAIT cycle drops the write; first tie afterwards goes to IF.
        s = hs_count;
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0300, 1'b1, 64'h1234_5678, 8'hFF);
        wait_grant(s, 1'b1, 10, t_ls);
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
        apply_stimulus(1'b0, 1'b1, 64'h8000_0400, 1'b1, 64'h8000_0500, 1'b0, 64'h0, 8'h0);
        s = hs_count;
        apply_stimulus(1'b1, 1'b1, 64'h8000_0400, 1'b1, 64'h8000_0500, 1'b0, 64'h0, 8'h0);
        wait_grant(s, 1'b0, 5, t_if);
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0);
        drain(20);

        // Single-cycle latency instance: IF read of 0x8000_0000.
        next_cycle();
        b_if_req_valid = 1'b1;
        b_if_req_addr  = 64'h8000_0000;
        check_output();
        check("b_if_req_ready", 64'(b_if_req_ready), 64'h1);
        check("b_ls_req_ready", 64'(b_ls_req_ready), 64'h0);
        next_cycle();
        b_if_req_valid = 1'b0;
        check_output();
        check("b_mem_en", 64'(b_mem_en), 64'h1);
        check("b_mem_addr", b_mem_addr, 64'h8000_0000);
        check("b_mem_wen", 64'(b_mem_wen), 64'h0);
        check("b_mem_wdata", b_mem_wdata, 64'h0);
        check("b_mem_wmask", 64'(b_mem_wmask), 64'h0);
        check("b_if_resp_early", 64'(b_if_resp_valid), 64'h0);
        next_cycle();
        check_output();
        check("b_if_resp_valid", 64'(b_if_resp_valid), 64'h1);
        check("b_if_resp_data", b_if_resp_data, 64'h0000_0000_0013_0413);
        check("b_ls_resp_valid", 64'(b_ls_resp_valid), 64'h0);
        check("b_ls_resp_data", b_ls_resp_data, 64'h0);
        check("b_mem_en_done", 64'(b_mem_en), 64'h0);
        next_cycle();
        check_output();
        check("b_if_resp_pulse", 64'(b_if_resp_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
